player_shot_unit: RTL and testbench



---
 rtl/stg_pkg.sv | 21 ++
 rtl/stg_first_free.sv | 19 +
 rtl/player_shot_unit.sv | 101 ++++++++++
 tb/tb_player_shot_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stg_pkg.sv
// stg_pkg: shared playfield constants, FSM states and boss hitbox test
package stg_pkg;
  localparam int MAX_X = 384;
  localparam int MAX_Y = 448;
  localparam int BOSS_HALF_L = 31;
  localparam int BOSS_HALF_R = 32;
  localparam int BOSS_HALF_T = 47;
  localparam int BOSS_HALF_B = 48;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_t;
  function automatic logic boss_hit(input logic [9:0] bx, input logic [9:0] by,
                                    input logic [9:0] cx, input logic [9:0] cy);
    logic [10:0] ax, ay, ox, oy;
    ax = {1'b0, bx};
    ay = {1'b0, by};
    ox = {1'b0, cx};
    oy = {1'b0, cy};
    return (ax + 11'(BOSS_HALF_L) >= ox) && (ax <= ox + 11'(BOSS_HALF_R)) &&
           (ay + 11'(BOSS_HALF_T) >= oy) && (ay <= oy + 11'(BOSS_HALF_B));
  endfunction
endpackage

// File: rtl/stg_first_free.sv
// stg_first_free: lowest-index inactive slot priority encoder
module stg_first_free #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  active,
  output logic [IW-1:0] idx,
  output logic          any_free
);
  always_comb begin
    idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (!active[i]) begin
        idx = IW'(i);
        any_free = 1'b1;
      end
  end
endmodule

// File: rtl/player_shot_unit.sv
// player_shot_unit: fires, moves, retires player bullets and reports boss hits
module player_shot_unit import stg_pkg::*; #(
  parameter int N_SLOTS = 8,
  parameter int TICK_CYCLES = 4000,
  parameter int SPEED = 4,
  parameter int COOLDOWN_TICKS = 6,
  parameter int SPAWN_DY = 8,
  parameter logic [RGB_W-1:0] BULLET_RGB = 12'hFF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire,
  input  logic [9:0]       player_x,
  input  logic [9:0]       player_y,
  input  logic [9:0]       boss_x,
  input  logic [9:0]       boss_y,
  input  logic             boss_alive,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic             bullet_on,
  output logic [RGB_W-1:0] rgb_out,
  output logic             is_hit,
  output logic [4:0]       active_count
);
  localparam int IW = $clog2(N_SLOTS);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int CW = $clog2(COOLDOWN_TICKS + 1);
  state_t state;
  logic [N_SLOTS-1:0] act;
  logic [9:0] bx [N_SLOTS];
  logic [9:0] by [N_SLOTS];
  logic [TW-1:0] cnt;
  logic [CW-1:0] cd;
  logic [IW-1:0] idx, free_idx;
  logic fp, hit_q, any_free, tick;
  logic [9:0] cy, ny;
  logic [4:0] pop;
  assign tick = cnt == TW'(TICK_CYCLES - 1);
  assign cy = by[idx];
  assign ny = cy - 10'(SPEED);
  assign is_hit = hit_q;
  assign rgb_out = bullet_on ? BULLET_RGB : '0;
  stg_first_free #(.N(N_SLOTS)) u_first_free (.active(act), .idx(free_idx), .any_free(any_free));
  always_comb begin
    pop = '0;
    bullet_on = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      pop = pop + 5'(act[i]);
      if (act[i] && 11'(x) + 11'd1 >= 11'(bx[i]) && 11'(x) <= 11'(bx[i]) + 11'd2 &&
          11'(y) + 11'd3 >= 11'(by[i]) && 11'(y) <= 11'(by[i]) + 11'd4)
        bullet_on = 1'b1;
    end
  end
  // Slot coordinates carry no reset; act gates every use of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      act <= '0;
      cnt <= '0;
      cd <= '0;
      fp <= 1'b0;
      idx <= '0;
      hit_q <= 1'b0;
      active_count <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      hit_q <= 1'b0;
      active_count <= pop;
      if (fire) fp <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state <= SCAN;
          idx <= '0;
        end
        SCAN: begin
          if (act[idx]) begin
            if (cy < 10'(SPEED)) act[idx] <= 1'b0;
            else if (boss_alive && boss_hit(bx[idx], ny, boss_x, boss_y)) begin
              act[idx] <= 1'b0;
              hit_q <= 1'b1;
            end else by[idx] <= ny;
          end
          if (idx == IW'(N_SLOTS - 1)) state <= SPAWN;
          idx <= idx + 1'b1;
        end
        SPAWN: begin
          if (cd != '0) cd <= cd - 1'b1;
          else if (fp && any_free && player_y >= 10'(SPAWN_DY)) begin
            act[free_idx] <= 1'b1;
            bx[free_idx] <= player_x;
            by[free_idx] <= player_y - 10'(SPAWN_DY);
            cd <= CW'(COOLDOWN_TICKS);
          end
          fp <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_player_shot_unit.sv
// tb_player_shot_unit: directed scenarios checked against a per-tick bullet model
module tb_player_shot_unit;
  localparam int N = 8, TC = 16, SPEED = 4, CDT = 6, SDY = 8;
  logic clk, reset, fire, boss_alive, bullet_on, is_hit;
  logic [9:0] player_x, player_y, boss_x, boss_y, x, y;
  logic [11:0] rgb_out;
  logic [4:0] active_count;
  int n_chk = 0, n_fail = 0, pulses = 0;
  int m_t, m_armed, m_sweeps, m_fp, m_cd, exp_hit, exp_cnt;
  int m_act [N], m_x [N], m_y [N];
  bit mvalid = 0;

  player_shot_unit #(.TICK_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .fire(fire), .player_x(player_x), .player_y(player_y),
    .boss_x(boss_x), .boss_y(boss_y), .boss_alive(boss_alive), .x(x), .y(y),
    .bullet_on(bullet_on), .rgb_out(rgb_out), .is_hit(is_hit), .active_count(active_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int in_box(input int bx, input int by);
    return int'(bx + 31 >= int'(boss_x) && bx <= int'(boss_x) + 32 &&
                by + 47 >= int'(boss_y) && by <= int'(boss_y) + 48);
  endfunction

  function automatic int pix();
    int r = 0;
    for (int i = 0; i < N; i++)
      if (m_act[i] != 0 && int'(x) + 1 >= m_x[i] && int'(x) <= m_x[i] + 2 &&
          int'(y) + 3 >= m_y[i] && int'(y) <= m_y[i] + 4) r = 1;
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: m_t mirrors the tick phase; slot m_t is swept at phase m_t, spawn at phase N.
  initial begin
    int pc, nh, ny, f;
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < N; i++) m_act[i] = 0;
        m_t = 0; m_armed = 0; m_fp = 0; m_cd = 0; exp_hit = 0; exp_cnt = 0; m_sweeps = 0;
        mvalid = 1;
      end else begin
        pc = 0;
        for (int i = 0; i < N; i++) pc += m_act[i];
        nh = 0;
        if (m_armed != 0 && m_t < N && m_act[m_t] != 0) begin
          if (m_y[m_t] < SPEED) m_act[m_t] = 0;
          else begin
            ny = m_y[m_t] - SPEED;
            if (boss_alive && in_box(m_x[m_t], ny) != 0) begin m_act[m_t] = 0; nh = 1; end
            else m_y[m_t] = ny;
          end
        end
        if (m_armed != 0 && m_t == N) begin
          if (m_cd > 0) m_cd--;
          else if (m_fp != 0) begin
            f = -1;
            for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) f = i;
            if (f >= 0 && int'(player_y) >= SDY) begin
              m_act[f] = 1; m_x[f] = int'(player_x); m_y[f] = int'(player_y) - SDY; m_cd = CDT;
            end
          end
          m_fp = 0;
          m_sweeps++;
        end else if (fire) m_fp = 1;
        if (m_t == TC - 1) m_armed = 1;
        m_t = (m_t + 1) % TC;
        exp_hit = nh;
        exp_cnt = pc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("is_hit", int'(is_hit), exp_hit);
      chk("active_count", int'(active_count), exp_cnt);
      chk("bullet_on", int'(bullet_on), pix());
      chk("rgb_out", int'(rgb_out), pix() != 0 ? 32'hFF0 : 0);
      if (is_hit) pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweeps(input int n);
    int target = m_sweeps + n, guard = 0;
    while (!(m_sweeps >= target && m_t == 10) && guard < 40 * n + 40) begin step(); guard++; end
    if (guard >= 40 * n + 40) chk("sweep_timeout", 1, 0);
  endtask

  task automatic probe(input string name, input int px, input int py, input int exp);
    x = 10'(px); y = 10'(py);
    #1;
    chk(name, int'(bullet_on), exp);
  endtask

  task automatic do_reset();
    reset = 1; fire = 0;
    step(); step();
    reset = 0;
  endtask

  task automatic pulse_fire();
    fire = 1; step(); fire = 0;
  endtask

  initial begin
    int p0, g;
    reset = 1; fire = 0; boss_alive = 0; player_x = 0; player_y = 0;
    boss_x = 0; boss_y = 0; x = 0; y = 0;
    do_reset();
    chk("reset_count", int'(active_count), 0);
    chk("reset_hit", int'(is_hit), 0);
    chk("reset_on", int'(bullet_on), 0);
    // single shot and render footprint
    player_x = 192; player_y = 400;
    pulse_fire();
    wait_sweeps(1);
    chk("shot_count", int'(active_count), 1);
    probe("shot_392", 192, 392, 1);
    chk("shot_rgb", int'(rgb_out), 32'hFF0);
    probe("shot_x_edge", 195, 392, 0);
    probe("shot_y_edge", 192, 397, 0);
    wait_sweeps(1);
    probe("move_193_390", 193, 390, 1);
    probe("move_195_390", 195, 390, 0);
    probe("move_top_in", 193, 385, 1);
    probe("move_top_out", 193, 384, 0);
    // hit with boss alive
    do_reset();
    player_x = 192; player_y = 160; boss_x = 192; boss_y = 100; boss_alive = 1;
    pulse_fire();
    wait_sweeps(1);
    chk("hit_pre_count", int'(active_count), 1);
    probe("hit_pre_152", 192, 152, 1);
    probe("hit_pre_157", 192, 157, 0);
    p0 = pulses;
    wait_sweeps(1);
    chk("hit_pulses", pulses - p0, 1);
    chk("hit_count", int'(active_count), 0);
    // same with boss dead
    do_reset();
    boss_alive = 0;
    pulse_fire();
    p0 = pulses;
    wait_sweeps(2);
    chk("dead_pulses", pulses - p0, 0);
    chk("dead_count", int'(active_count), 1);
    probe("dead_148", 192, 148, 1);
    probe("dead_153", 192, 153, 0);
    // off the top
    do_reset();
    player_x = 192; player_y = 11; boss_x = 350; boss_y = 400; boss_alive = 1;
    pulse_fire();
    wait_sweeps(1);
    chk("top_count1", int'(active_count), 1);
    probe("top_y3", 192, 3, 1);
    probe("top_y0", 192, 0, 1);
    p0 = pulses;
    wait_sweeps(1);
    chk("top_count0", int'(active_count), 0);
    chk("top_pulses", pulses - p0, 0);
    // cooldown with fire held
    do_reset();
    player_x = 100; player_y = 440; boss_x = 0; boss_y = 0; boss_alive = 0;
    fire = 1;
    for (int s = 1; s <= 16; s++) begin
      wait_sweeps(1);
      chk("cooldown_count", int'(active_count), int'(s >= 1) + int'(s >= 8) + int'(s >= 15));
    end
    // pool full, then a double hit that frees two slots before SPAWN
    do_reset();
    player_x = 50; player_y = 440; boss_x = 50; boss_y = 160; boss_alive = 0;
    fire = 1;
    wait_sweeps(50);
    chk("full_count", int'(active_count), 8);
    wait_sweeps(14);
    chk("full_dropped", int'(active_count), 8);
    boss_alive = 1;
    p0 = pulses;
    wait_sweeps(1);
    fire = 0;
    chk("double_pulses", pulses - p0, 2);
    chk("double_count", int'(active_count), 7);
    probe("respawn_432", 50, 432, 1);
    // reset in the middle of a scan
    do_reset();
    player_x = 192; player_y = 400; boss_alive = 0;
    pulse_fire();
    wait_sweeps(1);
    g = 0;
    while (m_t != 3 && g < 40) begin step(); g++; end
    chk("midscan_phase", m_t, 3);
    reset = 1;
    step();
    chk("midscan_count", int'(active_count), 0);
    chk("midscan_hit", int'(is_hit), 0);
    probe("midscan_on", 192, 388, 0);
    reset = 0;
    pulse_fire();
    wait_sweeps(1);
    chk("resume_count", int'(active_count), 1);
    probe("resume_392", 192, 392, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
